hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and pipeline-control unit for the 5-stage RV32I core.
- Drives the Stall/Flush inputs of the F/D, D/E and E/M pipeline registers and the E-stage forwarding muxes.
- Handles three hazard classes:
  - load-use hazards, by a 1-cycle bubble;
  - control hazards, by a wrong-path flush on a taken branch or jump;
  - multi-cycle data-memory accesses, by a ready/valid handshake that freezes the pipe.
- Keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of the stall_cnt and flush_cnt performance counters
LOAD_SRC, 2'b01, ResultSrcE encoding that identifies a load

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
Rs1D  in  5  rs1 of the instruction in D
Rs2D  in  5  rs2 of the instruction in D
Rs1E  in  5  rs1 of the instruction in E
Rs2E  in  5  rs2 of the instruction in E
RdE  in  5  destination register in E
ResultSrcE  in  2  result select in E
PCSrcE  in  1  taken branch or jump resolved in E
RdM  in  5  destination register in M
RegWriteM  in  1  register write enable in M
MemReqM  in  1  load or store present in M
mem_ready  in  1  data memory completes the M access this cycle
RdW  in  5  destination register in W
RegWriteW  in  1  register write enable in W
StallF  out  1  hold the PC register
StallD  out  1  hold the F/D register
StallE  out  1  hold the D/E register (drives its Stall input)
StallM  out  1  hold the E/M register
FlushD  out  1  clear the F/D register
FlushE  out  1  bubble in the D/E register (drives its Flush input)
ForwardAE  out  2  ALU operand A source: 00 regfile, 10 from M, 01 from W
ForwardBE  out  2  ALU operand B source, same encoding as ForwardAE
stall_cnt  out  CNT_W  total stalled cycles, saturating
flush_cnt  out  CNT_W  total flush events, saturating

Behaviour:
- Reset:
  - Asynchronous on rst_n low: state<=RST_FLUSH, stall_cnt<=0, flush_cnt<=0.
  - While rst_n is low, all Stall* outputs are 0, FlushD=FlushE=1, and ForwardAE/ForwardBE=00.
- States:
  - RST_FLUSH: lasts exactly one cycle after reset release. FlushD=FlushE=1, no stall, counters untouched. Next state is RUN.
  - RUN:
    - If MemReqM && !mem_ready: StallF/D/E/M=1 and FlushD=FlushE=0 in the same cycle; next state is MEM_WAIT.
    - Else if PCSrcE: FlushD=FlushE=1, no stall, flush_cnt+1.
    - Else if load-use: StallF=StallD=1, FlushE=1, StallE=StallM=0, stall_cnt+1.
    - Load-use = (ResultSrcE==LOAD_SRC) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
    - A branch taken in the same cycle as a load-use hazard takes the branch path only; the D instruction is wrong-path.
  - MEM_WAIT:
    - StallF/D/E/M=1 and FlushD=FlushE=0 every cycle until mem_ready=1.
    - stall_cnt+1 for every MEM_WAIT cycle, including the cycle in which mem_ready rises.
    - On mem_ready=1 the stalls still hold in that cycle and the next state is RUN.
    - A pending PCSrcE or load-use hazard is frozen with E and is serviced in the first RUN cycle.
- Invariants:
  - FlushE is never asserted together with StallE, because the D/E register ignores Flush while stalled.
  - FlushD is never asserted together with StallD.
- Stall and flush outputs are combinational from state and inputs; state and counters are registered.
- Forwarding (combinational, independent of state):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else ForwardAE=00.
  - ForwardBE uses the same rules with Rs2E.
  - M takes priority over W. x0 is never forwarded.
- Counters: increment by 1, saturate at all-ones (no wrap).
- Latency: all control outputs take effect on the next clk edge in the target registers; 0-cycle decision.

Decomposition:
- Shared package cpu_pkg holds:
  - the hazard_state_t enum {RST_FLUSH, RUN, MEM_WAIT};
  - the fwd_sel_t constants FWD_REG=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - RESULT_LOAD=2'b01.
- One sub-module, fwd_unit, holds the pure combinational forwarding logic, instantiated once.
- Counters and FSM stay in hazard_ctrl.

Test Plan:
- Reset: rst_n=0 for 3 cycles, then release -> FlushD=FlushE=1 for exactly 1 cycle after release; stall_cnt=flush_cnt=0; then all controls 0.
- Load-use: ResultSrcE=01, RdE=5, Rs2D=5 -> StallF=StallD=1, FlushE=1, StallE=0 for 1 cycle; stall_cnt=1. Repeat with RdE=0 -> no stall.
- Branch+load-use: PCSrcE=1 and load-use condition together -> FlushD=FlushE=1, no stall, flush_cnt=1, stall_cnt unchanged.
- Memory wait: MemReqM=1, mem_ready=0 for 4 cycles then 1 -> StallF/D/E/M=1 for 5 cycles, never FlushE; stall_cnt=5; PCSrcE=1 held throughout -> flush on the first RUN cycle.
- Forwarding: RegWriteM=1, RdM=7; RegWriteW=1, RdW=7; Rs1E=7 -> ForwardAE=10. With RegWriteM=0 -> 01. With Rs1E=0 and RdM=RdW=0 -> 00.
- Saturation: CNT_W=4, 20 load-use cycles -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32I core pipeline-control logic.
//   hazard_state_t : hazard-unit FSM states
//   fwd_sel_t      : E-stage forwarding mux select (FWD_REG/FWD_W/FWD_M)
//   RESULT_LOAD    : ResultSrc encoding of a load
//   fwd_pick()     : forwarding priority rule for one ALU operand
package cpu_pkg;

  typedef enum logic [1:0] {
    RST_FLUSH = 2'd0,
    RUN       = 2'd1,
    MEM_WAIT  = 2'd2
  } hazard_state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG = 2'b00;
  localparam fwd_sel_t FWD_W   = 2'b01;
  localparam fwd_sel_t FWD_M   = 2'b10;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // M is younger than W, so its value wins; x0 is hardwired and never forwarded.
  function automatic fwd_sel_t fwd_pick(input logic [4:0] rs,
                                        input logic [4:0] rd_m, input logic wr_m,
                                        input logic [4:0] rd_w, input logic wr_w);
    if (wr_m && rd_m != 5'd0 && rd_m == rs)      return FWD_M;
    else if (wr_w && rd_w != 5'd0 && rd_w == rs) return FWD_W;
    else                                         return FWD_REG;
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// E-stage forwarding unit (pure combinational).
//   rs_e_i        : source registers of the E instruction, [0]=rs1, [1]=rs2
//   rd_m_i/_w_i   : destination registers in M and W
//   reg_write_*_i : register write enables in M and W
//   fwd_o         : per-operand mux select, [0]=A, [1]=B
module fwd_unit
  import cpu_pkg::*;
#(
  parameter int NUM_OPS = 2
) (
  input  logic [NUM_OPS-1:0][4:0] rs_e_i,
  input  logic [4:0]              rd_m_i,
  input  logic                    reg_write_m_i,
  input  logic [4:0]              rd_w_i,
  input  logic                    reg_write_w_i,
  output fwd_sel_t [NUM_OPS-1:0]  fwd_o
);

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    assign fwd_o[g] = fwd_pick(rs_e_i[g], rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage RV32I core.
// Resolves load-use hazards (1-cycle bubble), taken branches/jumps
// (wrong-path flush) and multi-cycle data-memory accesses (whole-pipe
// freeze), drives E-stage forwarding and keeps saturating perf counters.
//   clk, rst_n             : clock, asynchronous active-low reset
//   Rs1D/Rs2D              : sources of the D instruction
//   Rs1E/Rs2E/RdE          : sources/destination of the E instruction
//   ResultSrcE, PCSrcE     : load detection, taken branch/jump in E
//   RdM/RegWriteM/MemReqM  : M-stage destination, write enable, memory access
//   mem_ready              : data memory completes the M access this cycle
//   RdW/RegWriteW          : W-stage destination and write enable
//   Stall*/Flush*          : pipeline register controls
//   ForwardAE/ForwardBE    : E-stage operand mux selects
//   stall_cnt/flush_cnt    : saturating stall-cycle / flush-event counters
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int         CNT_W    = 16,
  parameter logic [1:0] LOAD_SRC = RESULT_LOAD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic             MemReqM,
  input  logic             mem_ready,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t    state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use, mem_hold;
  logic             stall_inc, flush_inc;
  fwd_sel_t [1:0]   fwd;

  assign load_use = (ResultSrcE == LOAD_SRC) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_hold = MemReqM && !mem_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST_FLUSH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RST_FLUSH: state_d = RUN;
      RUN:       if (mem_hold) state_d = MEM_WAIT;
      MEM_WAIT:  if (mem_ready) state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  // Output logic. Flushes are only raised when the matching stage is not
  // stalled: the D/E register ignores Flush while its Stall is high, so a
  // branch or bubble during a memory freeze must wait until the pipe moves.
  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_hold) begin
          {StallF, StallD, StallE, StallM} = 4'hF;
          stall_inc = 1'b1;
        end else if (PCSrcE) begin
          // Branch wins over load-use: the D instruction is wrong-path anyway.
          FlushD    = 1'b1;
          FlushE    = 1'b1;
          flush_inc = 1'b1;
        end else if (load_use) begin
          StallF    = 1'b1;
          StallD    = 1'b1;
          FlushE    = 1'b1;
          stall_inc = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Held through the mem_ready cycle so M commits before the pipe advances.
        {StallF, StallD, StallE, StallM} = 4'hF;
        stall_inc = 1'b1;
      end
      default: begin
        // RST_FLUSH (and any illegal encoding): clear the front of the pipe.
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
    endcase
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_inc && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  fwd_unit #(.NUM_OPS(2)) u_fwd (
    .rs_e_i        ({Rs2E, Rs1E}),
    .rd_m_i        (RdM),
    .reg_write_m_i (RegWriteM),
    .rd_w_i        (RdW),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (fwd)
  );

  // Forwarding is held at the register file while in reset.
  assign ForwardAE = rst_n ? fwd[0] : FWD_REG;
  assign ForwardBE = rst_n ? fwd[1] : FWD_REG;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
    logic [1:0] rsrc;
    logic       pc;
    logic [4:0] rdm;
    logic       rwm, mreq, rdy;
    logic [4:0] rdw;
    logic       rww;
  } vec_t;

  // ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE}
  typedef struct {
    vec_t       v;
    logic [5:0] ctrl;
    logic [1:0] fa, fb;
    int         sc, fc;
  } rec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, RegWriteM, MemReqM, mem_ready, RegWriteW;

  logic SF, SD, SE, SM, FD, FE;
  logic [1:0] FA, FB;
  logic [15:0] sc16, fc16;
  logic sSF, sSD, sSE, sSM, sFD, sFE;
  logic [1:0] sFA, sFB;
  logic [3:0] sc4, fc4;

  int n_chk = 0, n_fail = 0;

  // Behavioural reference state
  bit post_reset, mem_busy;
  int n_stall, n_flush;

  always #5 clk = ~clk;

  hazard_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
    .MemReqM(MemReqM), .mem_ready(mem_ready), .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(SF), .StallD(SD), .StallE(SE), .StallM(SM), .FlushD(FD), .FlushE(FE),
    .ForwardAE(FA), .ForwardBE(FB), .stall_cnt(sc16), .flush_cnt(fc16));

  hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RegWriteM(RegWriteM),
    .MemReqM(MemReqM), .mem_ready(mem_ready), .RdW(RdW), .RegWriteW(RegWriteW),
    .StallF(sSF), .StallD(sSD), .StallE(sSE), .StallM(sSM), .FlushD(sFD), .FlushE(sFE),
    .ForwardAE(sFA), .ForwardBE(sFB), .stall_cnt(sc4), .flush_cnt(fc4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{rs1d:0, rs2d:0, rs1e:0, rs2e:0, rde:0, rsrc:0, pc:0, rdm:0, rwm:0,
          mreq:0, rdy:0, rdw:0, rww:0};
    return v;
  endfunction

  function automatic vec_t VF(input logic [4:0] rs1e, rs2e, rdm, input logic rwm,
                              input logic [4:0] rdw, input logic rww);
    vec_t v = idle();
    v.rs1e = rs1e; v.rs2e = rs2e; v.rdm = rdm; v.rwm = rwm; v.rdw = rdw; v.rww = rww;
    return v;
  endfunction

  function automatic vec_t VL(input logic [1:0] rsrc, input logic [4:0] rde, rs1d, rs2d,
                              input logic pc);
    vec_t v = idle();
    v.rsrc = rsrc; v.rde = rde; v.rs1d = rs1d; v.rs2d = rs2d; v.pc = pc;
    return v;
  endfunction

  function automatic vec_t VM(input logic mreq, rdy, pc);
    vec_t v = idle();
    v.mreq = mreq; v.rdy = rdy; v.pc = pc;
    return v;
  endfunction

  function automatic rec_t R(input vec_t v, input logic [5:0] c, input logic [1:0] fa, fb,
                             input int sc, fc);
    rec_t r;
    r.v = v; r.ctrl = c; r.fa = fa; r.fb = fb; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input vec_t v);
    if (v.rwm && v.rdm != 0 && v.rdm == rs) return 2'b10;
    if (v.rww && v.rdw != 0 && v.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int sat(input int n, input int w);
    int mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic drive(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde;
    ResultSrcE = v.rsrc; PCSrcE = v.pc; RdM = v.rdm; RegWriteM = v.rwm;
    MemReqM = v.mreq; mem_ready = v.rdy; RdW = v.rdw; RegWriteW = v.rww;
  endtask

  // Called just after a falling edge: apply, check against the model (and
  // optionally a table record), advance the model, move to the next falling edge.
  task automatic step(input string tag, input vec_t v, input bit use_rec, input rec_t r);
    logic [5:0] exp_ctrl;
    bit lu, frozen;
    drive(v);
    #1;
    lu = (v.rsrc == 2'b01) && v.rde != 0 && (v.rde == v.rs1d || v.rde == v.rs2d);
    frozen = 1'b0;
    if (post_reset)                         exp_ctrl = 6'b000011;
    else if (mem_busy || (v.mreq && !v.rdy)) begin exp_ctrl = 6'b111100; frozen = 1'b1; end
    else if (v.pc)                          exp_ctrl = 6'b000011;
    else if (lu)                            exp_ctrl = 6'b110001;
    else                                    exp_ctrl = 6'b000000;

    chk({tag, " ctrl"},  {26'd0, SF, SD, SE, SM, FD, FE}, {26'd0, exp_ctrl});
    chk({tag, " fwdA"},  {30'd0, FA}, {30'd0, ref_fwd(v.rs1e, v)});
    chk({tag, " fwdB"},  {30'd0, FB}, {30'd0, ref_fwd(v.rs2e, v)});
    chk({tag, " stall"}, {16'd0, sc16}, sat(n_stall, 16));
    chk({tag, " flush"}, {16'd0, fc16}, sat(n_flush, 16));
    chk({tag, " ctrl4"}, {26'd0, sSF, sSD, sSE, sSM, sFD, sFE}, {26'd0, exp_ctrl});
    chk({tag, " stall4"}, {28'd0, sc4}, sat(n_stall, 4));
    chk({tag, " flush4"}, {28'd0, fc4}, sat(n_flush, 4));
    if (use_rec) begin
      chk({tag, " tbl ctrl"},  {26'd0, SF, SD, SE, SM, FD, FE}, {26'd0, r.ctrl});
      chk({tag, " tbl fwdA"},  {30'd0, FA}, {30'd0, r.fa});
      chk({tag, " tbl fwdB"},  {30'd0, FB}, {30'd0, r.fb});
      chk({tag, " tbl stall"}, {16'd0, sc16}, r.sc);
      chk({tag, " tbl flush"}, {16'd0, fc16}, r.fc);
    end

    if (post_reset) post_reset = 1'b0;
    else if (frozen) begin n_stall++; mem_busy = !v.rdy; end
    else if (v.pc) n_flush++;
    else if (lu)   n_stall++;
    @(negedge clk);
  endtask

  rec_t tbl[21];
  rec_t none;
  vec_t rv;

  initial begin
    none = R(idle(), 0, 0, 0, 0, 0);
    tbl[0]  = R(VF(7, 0, 7, 1, 7, 1), 6'b000011, 2'b10, 2'b00, 0, 0); // reset flush cycle
    tbl[1]  = R(VF(7, 0, 7, 0, 7, 1), 6'b000000, 2'b01, 2'b00, 0, 0);
    tbl[2]  = R(VF(0, 0, 0, 1, 0, 1), 6'b000000, 2'b00, 2'b00, 0, 0);
    tbl[3]  = R(VF(3, 9, 9, 0, 9, 1), 6'b000000, 2'b00, 2'b01, 0, 0);
    tbl[4]  = R(VF(9, 9, 9, 1, 4, 1), 6'b000000, 2'b10, 2'b10, 0, 0);
    tbl[5]  = R(VL(2'b01, 5, 0, 5, 0), 6'b110001, 2'b00, 2'b00, 0, 0); // load-use via rs2
    tbl[6]  = R(idle(),                6'b000000, 2'b00, 2'b00, 1, 0);
    tbl[7]  = R(VL(2'b01, 0, 0, 0, 0), 6'b000000, 2'b00, 2'b00, 1, 0); // RdE = x0
    tbl[8]  = R(VL(2'b01, 5, 5, 0, 1), 6'b000011, 2'b00, 2'b00, 1, 0); // branch + load-use
    tbl[9]  = R(idle(),                6'b000000, 2'b00, 2'b00, 1, 1);
    tbl[10] = R(VL(2'b10, 5, 5, 0, 0), 6'b000000, 2'b00, 2'b00, 1, 1); // not a load
    tbl[11] = R(VM(1, 0, 1),           6'b111100, 2'b00, 2'b00, 1, 1); // memory wait
    tbl[12] = R(VM(1, 0, 1),           6'b111100, 2'b00, 2'b00, 2, 1);
    tbl[13] = R(VM(1, 0, 1),           6'b111100, 2'b00, 2'b00, 3, 1);
    tbl[14] = R(VM(1, 0, 1),           6'b111100, 2'b00, 2'b00, 4, 1);
    tbl[15] = R(VM(1, 1, 1),           6'b111100, 2'b00, 2'b00, 5, 1);
    tbl[16] = R(VM(0, 0, 1),           6'b000011, 2'b00, 2'b00, 6, 1); // pending branch
    tbl[17] = R(idle(),                6'b000000, 2'b00, 2'b00, 6, 2);
    tbl[18] = R(VM(1, 1, 0),           6'b000000, 2'b00, 2'b00, 6, 2); // ready at once
    tbl[19] = R(VL(2'b01, 6, 6, 0, 0), 6'b110001, 2'b00, 2'b00, 6, 2); // load-use via rs1
    tbl[20] = R(idle(),                6'b000000, 2'b00, 2'b00, 7, 2);

    // Reset: controls that would otherwise stall and forward are held off.
    rv = VF(7, 7, 7, 1, 7, 1);
    rv.mreq = 1; rv.pc = 1; rv.rsrc = 2'b01; rv.rde = 3; rv.rs1d = 3;
    drive(rv);
    post_reset = 1'b1; mem_busy = 1'b0; n_stall = 0; n_flush = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("rst%0d ctrl", i), {26'd0, SF, SD, SE, SM, FD, FE}, 32'b000011);
      chk($sformatf("rst%0d fwd", i), {28'd0, FA, FB}, 32'd0);
      chk($sformatf("rst%0d cnt", i), {sc16, fc16}, 32'd0);
    end
    rst_n = 1'b1;

    foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i].v, 1'b1, tbl[i]);

    // Saturation of the 4-bit counters under continuous load-use
    for (int i = 0; i < 20; i++) step($sformatf("sat%0d", i), VL(2'b01, 5, 5, 0, 0), 1'b0, none);
    chk("sat stall4 hold", {28'd0, sc4}, 32'd15);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rv.rs1d = 5'($urandom_range(0, 3)); rv.rs2d = 5'($urandom_range(0, 3));
      rv.rs1e = 5'($urandom_range(0, 3)); rv.rs2e = 5'($urandom_range(0, 3));
      rv.rde  = 5'($urandom_range(0, 3)); rv.rsrc = 2'($urandom_range(0, 3));
      rv.pc   = ($urandom_range(0, 5) == 0);
      rv.rdm  = 5'($urandom_range(0, 3)); rv.rwm = 1'($urandom_range(0, 1));
      rv.mreq = ($urandom_range(0, 3) == 0); rv.rdy = 1'($urandom_range(0, 1));
      rv.rdw  = 5'($urandom_range(0, 3)); rv.rww = 1'($urandom_range(0, 1));
      step($sformatf("rnd%0d", i), rv, 1'b0, none);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
